// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage RV32I pipeline: stall/flush sequencing, operand forwarding, memory watchdog.
// Optional performance counters are built only when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl #(
  parameter int REG_AW   = 5,
  parameter int WAIT_MAX = 255,
  parameter int CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] rs1_D,
  input  logic [REG_AW-1:0] rs2_D,
  input  logic              use_rs1_D,
  input  logic              use_rs2_D,
  input  logic [REG_AW-1:0] rs1_E,
  input  logic [REG_AW-1:0] rs2_E,
  input  logic [REG_AW-1:0] rd_E,
  input  logic              load_E,
  input  logic              PCSrc_E,
  input  logic              RegWrite_M,
  input  logic              RegWrite_W,
  input  logic [REG_AW-1:0] rd_M,
  input  logic [REG_AW-1:0] rd_W,
  input  logic              dmem_req_M,
  input  logic              dmem_ready,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              StallM,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushW,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
`ifdef HAZARD_PERF_CNT_EN
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt,
  output logic [CNT_W-1:0]  memwait_cnt,
`endif
  output logic              fault
);

  localparam int WCW = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);

  typedef enum logic [1:0] {RUN, LU_STALL, MEM_WAIT, FAULT} state_t;

  state_t         state_reg;
  logic [WCW-1:0] wait_cnt_reg;
  logic           fault_reg;

  logic mem_wait;
  logic lu_haz;
  logic stall_all, lu_stall, br_flush;

  // Forwarding for both E operands; M result has priority over W.
  logic [REG_AW-1:0] rs_e [2];
  logic [1:0]        fwd  [2];
  assign rs_e[0] = rs1_E;
  assign rs_e[1] = rs2_E;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      always_comb begin
        fwd[gi] = 2'b00;
        if (RegWrite_M && rd_M != '0 && rd_M == rs_e[gi])
          fwd[gi] = 2'b10;
        else if (RegWrite_W && rd_W != '0 && rd_W == rs_e[gi])
          fwd[gi] = 2'b01;
      end
    end
  endgenerate

  assign ForwardAE = fwd[0];
  assign ForwardBE = fwd[1];

  assign mem_wait = dmem_req_M & ~dmem_ready;
  assign lu_haz   = load_E & (rd_E != '0) &
                    ((use_rs1_D & (rs1_D == rd_E)) | (use_rs2_D & (rs2_D == rd_E)));

  // RUN, LU_STALL and MEM_WAIT share one priority decode; only FAULT overrides it.
  always_comb begin
    stall_all = 1'b0;
    lu_stall  = 1'b0;
    br_flush  = 1'b0;
    if (state_reg == FAULT || mem_wait)
      stall_all = 1'b1;
    else if (PCSrc_E)
      br_flush = 1'b1;
    else if (lu_haz)
      lu_stall = 1'b1;
  end

  // Gating with rst_n drives every control low the moment reset asserts.
  assign StallF = (stall_all | lu_stall) & rst_n;
  assign StallD = (stall_all | lu_stall) & rst_n;
  assign StallE = stall_all & rst_n;
  assign StallM = stall_all & rst_n;
  assign FlushD = br_flush & rst_n;
  assign FlushE = (br_flush | lu_stall) & rst_n;
  assign FlushW = stall_all & rst_n;
  assign fault  = fault_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= RUN;
      wait_cnt_reg <= '0;
      fault_reg    <= 1'b0;
    end else begin
      case (state_reg)
        FAULT: state_reg <= FAULT;
        MEM_WAIT: begin
          if (mem_wait) begin
            if (wait_cnt_reg == WCW'(WAIT_MAX)) begin
              state_reg <= FAULT;
              fault_reg <= 1'b1;
            end else begin
              wait_cnt_reg <= wait_cnt_reg + 1'b1;
            end
          end else begin
            wait_cnt_reg <= '0;
            state_reg    <= lu_stall ? LU_STALL : RUN;
          end
        end
        default: begin
          if (mem_wait) begin
            state_reg    <= MEM_WAIT;
            wait_cnt_reg <= WCW'(1);
          end else begin
            state_reg <= lu_stall ? LU_STALL : RUN;
          end
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_reg, flush_cnt_reg, memwait_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_reg   <= '0;
      flush_cnt_reg   <= '0;
      memwait_cnt_reg <= '0;
    end else begin
      if (lu_stall && stall_cnt_reg != '1)
        stall_cnt_reg <= stall_cnt_reg + 1'b1;
      if (br_flush && flush_cnt_reg != '1)
        flush_cnt_reg <= flush_cnt_reg + 1'b1;
      if (stall_all && memwait_cnt_reg != '1)
        memwait_cnt_reg <= memwait_cnt_reg + 1'b1;
    end
  end

  assign stall_cnt   = stall_cnt_reg;
  assign flush_cnt   = flush_cnt_reg;
  assign memwait_cnt = memwait_cnt_reg;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a vector table walked cycle by cycle, then watchdog and async-reset sequences.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W;
  logic       use_rs1_D, use_rs2_D, load_E, PCSrc_E, RegWrite_M, RegWrite_W;
  logic       dmem_req_M, dmem_ready;
  logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, fault;
  logic [1:0] ForwardAE, ForwardBE;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_AW(5), .WAIT_MAX(8), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_D(rs1_D), .rs2_D(rs2_D), .use_rs1_D(use_rs1_D), .use_rs2_D(use_rs2_D),
    .rs1_E(rs1_E), .rs2_E(rs2_E), .rd_E(rd_E), .load_E(load_E), .PCSrc_E(PCSrc_E),
    .RegWrite_M(RegWrite_M), .RegWrite_W(RegWrite_W), .rd_M(rd_M), .rd_W(rd_W),
    .dmem_req_M(dmem_req_M), .dmem_ready(dmem_ready),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .fault(fault)
  );

  typedef struct {
    logic [4:0] rs1d; logic u1; logic [4:0] rs2d; logic u2;
    logic [4:0] rs1e, rs2e, rde; logic lde, pcs;
    logic rwm; logic [4:0] rdm; logic rww; logic [4:0] rdw;
    logic req, rdy;
    logic [3:0] st;   // {F,D,E,M}
    logic [2:0] fl;   // {D,E,W}
    logic [1:0] fa, fb;
  } vec_t;

  localparam int NV = 25;
  vec_t vecs [NV];

  function automatic vec_t mk(
      input logic [4:0] rs1d, input logic u1, input logic [4:0] rs2d, input logic u2,
      input logic [4:0] rs1e, input logic [4:0] rs2e, input logic [4:0] rde,
      input logic lde, input logic pcs,
      input logic rwm, input logic [4:0] rdm, input logic rww, input logic [4:0] rdw,
      input logic req, input logic rdy,
      input logic [3:0] st, input logic [2:0] fl, input logic [1:0] fa, input logic [1:0] fb);
    vec_t v;
    v.rs1d = rs1d; v.u1 = u1; v.rs2d = rs2d; v.u2 = u2;
    v.rs1e = rs1e; v.rs2e = rs2e; v.rde = rde; v.lde = lde; v.pcs = pcs;
    v.rwm = rwm; v.rdm = rdm; v.rww = rww; v.rdw = rdw;
    v.req = req; v.rdy = rdy; v.st = st; v.fl = fl; v.fa = fa; v.fb = fb;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    rs1_D = v.rs1d; use_rs1_D = v.u1; rs2_D = v.rs2d; use_rs2_D = v.u2;
    rs1_E = v.rs1e; rs2_E = v.rs2e; rd_E = v.rde; load_E = v.lde; PCSrc_E = v.pcs;
    RegWrite_M = v.rwm; rd_M = v.rdm; RegWrite_W = v.rww; rd_W = v.rdw;
    dmem_req_M = v.req; dmem_ready = v.rdy;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp_v);
    end
  endtask

  task automatic chk_ctrl(input string name, input logic [3:0] st, input logic [2:0] fl, input logic flt);
    chk({name, ".stall"}, {4'h0, StallF, StallD, StallE, StallM}, {4'h0, st});
    chk({name, ".flush"}, {5'h0, FlushD, FlushE, FlushW}, {5'h0, fl});
    chk({name, ".fault"}, {7'h0, fault}, {7'h0, flt});
  endtask

  initial begin
    vec_t idle, w;
    //            rs1d u1 rs2d u2 rs1e rs2e rde lde pcs rwm rdm rww rdw req rdy st      fl      fa     fb
    idle     = mk(0,   0, 0,   0, 0,   0,   0,  0,  0,  0,  0,  0,  0,  0,  1,  4'b0000,3'b000,2'b00,2'b00);
    vecs[0]  = idle;
    vecs[1]  = mk(0,   0, 0,   0, 3,   0,   0,  0,  0,  1,  3,  1,  3,  0,  1,  4'b0000,3'b000,2'b10,2'b00);
    vecs[2]  = mk(0,   0, 0,   0, 3,   3,   0,  0,  0,  1,  0,  1,  3,  0,  1,  4'b0000,3'b000,2'b01,2'b01);
    vecs[3]  = mk(0,   0, 0,   0, 0,   0,   0,  0,  0,  1,  0,  1,  0,  0,  1,  4'b0000,3'b000,2'b00,2'b00);
    vecs[4]  = mk(0,   0, 0,   0, 7,   7,   0,  0,  0,  0,  7,  1,  7,  0,  1,  4'b0000,3'b000,2'b01,2'b01);
    vecs[5]  = mk(0,   0, 0,   0, 4,   9,   0,  0,  0,  1,  9,  1,  4,  0,  1,  4'b0000,3'b000,2'b01,2'b10);
    vecs[6]  = mk(5,   1, 0,   0, 0,   0,   5,  1,  0,  0,  0,  0,  0,  0,  1,  4'b1100,3'b010,2'b00,2'b00);
    vecs[7]  = mk(5,   1, 0,   0, 0,   0,   0,  0,  0,  1,  5,  0,  0,  0,  1,  4'b0000,3'b000,2'b00,2'b00);
    vecs[8]  = mk(0,   0, 0,   0, 5,   0,   0,  0,  0,  0,  0,  1,  5,  0,  1,  4'b0000,3'b000,2'b01,2'b00);
    vecs[9]  = mk(0,   0, 6,   0, 0,   0,   6,  1,  0,  0,  0,  0,  0,  0,  1,  4'b0000,3'b000,2'b00,2'b00);
    vecs[10] = mk(0,   1, 0,   0, 0,   0,   0,  1,  0,  0,  0,  0,  0,  0,  1,  4'b0000,3'b000,2'b00,2'b00);
    vecs[11] = mk(0,   0, 6,   1, 0,   0,   6,  1,  0,  0,  0,  0,  0,  0,  1,  4'b1100,3'b010,2'b00,2'b00);
    vecs[12] = mk(8,   1, 0,   0, 0,   0,   8,  1,  0,  1,  6,  0,  0,  0,  1,  4'b1100,3'b010,2'b00,2'b00);
    vecs[13] = mk(0,   0, 0,   0, 0,   0,   0,  0,  1,  0,  0,  0,  0,  0,  1,  4'b0000,3'b110,2'b00,2'b00);
    vecs[14] = mk(2,   1, 0,   0, 0,   0,   2,  1,  1,  0,  0,  0,  0,  0,  1,  4'b0000,3'b110,2'b00,2'b00);
    vecs[15] = idle;
    w        = mk(0,   0, 0,   0, 0,   0,   0,  0,  1,  0,  0,  0,  0,  1,  0,  4'b1111,3'b001,2'b00,2'b00);
    for (int i = 16; i < 20; i++) vecs[i] = w;
    vecs[20] = mk(0,   0, 0,   0, 0,   0,   0,  0,  1,  0,  0,  0,  0,  1,  1,  4'b0000,3'b110,2'b00,2'b00);
    vecs[21] = idle;
    vecs[22] = mk(5,   1, 0,   0, 0,   0,   5,  1,  0,  0,  0,  0,  0,  1,  0,  4'b1111,3'b001,2'b00,2'b00);
    vecs[23] = mk(5,   1, 0,   0, 0,   0,   5,  1,  0,  0,  0,  0,  0,  1,  1,  4'b1100,3'b010,2'b00,2'b00);
    vecs[24] = idle;

    // Reset with a pending memory wait on the inputs: controls must still read 0.
    w = idle; w.req = 1'b1; w.rdy = 1'b0;
    drive(w);
    rst_n = 1'b0;
    #2;
    chk_ctrl("reset", 4'b0000, 3'b000, 1'b0);
    @(negedge clk);
    drive(idle);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      chk_ctrl($sformatf("vec%0d", i), vecs[i].st, vecs[i].fl, 1'b0);
      chk($sformatf("vec%0d.fwd", i), {4'h0, ForwardAE, ForwardBE}, {4'h0, vecs[i].fa, vecs[i].fb});
      $display("vec%0d stall=%b%b%b%b flush=%b%b%b fa=%b fb=%b", i,
               StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, ForwardAE, ForwardBE);
    end

    // Watchdog: nine wait cycles exhaust WAIT_MAX=8, FAULT appears on the tenth.
    w = idle; w.req = 1'b1; w.rdy = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      drive(w);
      #1;
      chk_ctrl($sformatf("wait%0d", c), 4'b1111, 3'b001, 1'b0);
      $display("wait cycle %0d fault=%b", c, fault);
    end
    @(negedge clk);
    #1;
    chk_ctrl("fault_entry", 4'b1111, 3'b001, 1'b1);
    $display("fault entry fault=%b", fault);

    // No input releases FAULT, not even a ready memory or a branch.
    @(negedge clk);
    w = idle; w.pcs = 1'b1;
    drive(w);
    #1;
    chk_ctrl("fault_hold", 4'b1111, 3'b001, 1'b1);
    @(negedge clk);
    #1;
    chk_ctrl("fault_hold2", 4'b1111, 3'b001, 1'b1);
    $display("fault hold fault=%b", fault);

    // Asynchronous reset pulse mid-cycle, away from any clock edge.
    w = idle; w.req = 1'b1; w.rdy = 1'b0;
    drive(w);
    #1;
    rst_n = 1'b0;
    #1;
    chk_ctrl("async_reset", 4'b0000, 3'b000, 1'b0);
    $display("async reset fault=%b stallF=%b", fault, StallF);
    @(negedge clk);
    drive(idle);
    rst_n = 1'b1;
    #1;
    chk_ctrl("after_reset", 4'b0000, 3'b000, 1'b0);

    // After reset the FSM is back in RUN: a fresh wait then ready exits cleanly.
    @(negedge clk);
    drive(w);
    #1;
    chk_ctrl("rerun_wait", 4'b1111, 3'b001, 1'b0);
    @(negedge clk);
    w.rdy = 1'b1;
    drive(w);
    #1;
    chk_ctrl("rerun_ready", 4'b0000, 3'b000, 1'b0);
    @(negedge clk);
    drive(idle);
    #1;
    chk_ctrl("rerun_idle", 4'b0000, 3'b000, 1'b0);
    $display("rerun done stall=%b%b%b%b", StallF, StallD, StallE, StallM);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
